// File: rtl/branch_target_table.sv
// branch_target_table
//   Programmable branch-target table for the fetch stage. It has N entries.
//   Each entry holds a D-bit value and a mode bit:
//     - absolute entry: the value is the target.
//     - relative entry: the value is a two's-complement offset added to pc.
//   After reset, a hardware init sequence reloads the boot defaults, one
//   entry per cycle, for N cycles. Lookups are registered and take one cycle.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   branch        lookup request (ignored during init)
//   idx           entry to look up
//   pc            current PC, used by relative entries
//   wr_en         runtime write request (ignored during init)
//   wr_idx        entry to write
//   wr_target     new value (absolute target or signed offset)
//   wr_rel        new mode bit (1 = relative)
//   ready         init done, lookups and writes accepted
//   target        resolved target; zero when no lookup is in flight
//   target_valid  target holds a lookup result this cycle
//
// Configuration macro
//   BTT_BYPASS_EN  when defined, a write to the entry being looked up in the
//                  same cycle is forwarded into the lookup. When undefined,
//                  the lookup reads the old contents (read-before-write).
module branch_target_table #(
  parameter int D = 8,
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          branch,
  input  logic [IW-1:0] idx,
  input  logic [D-1:0]  pc,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [D-1:0]  wr_target,
  input  logic          wr_rel,
  output logic          ready,
  output logic [D-1:0]  target,
  output logic          target_valid
);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic         rel;
    logic [D-1:0] val;
  } entry_t;

  state_t                state;
  logic [IW-1:0]         cnt;
  entry_t [N-1:0]        tbl;

  entry_t                init_e;
  entry_t                tbl_wd;
  entry_t                rd_e;
  logic                  tbl_we;
  logic [IW-1:0]         tbl_wi;
  logic [D-1:0]          res;

  // Boot defaults: entry 0 -> 4, entry 1 -> 8, all others -> 0.
  // Every default entry is absolute.
  always_comb begin
    init_e.rel = 1'b0;
    init_e.val = '0;
    if (cnt == '0)
      init_e.val = D'(4);
    else if (cnt == IW'(1))
      init_e.val = D'(8);
  end

  // One write port. The init sequencer owns it during INIT.
  always_comb begin
    tbl_we     = wr_en;
    tbl_wi     = wr_idx;
    tbl_wd.rel = wr_rel;
    tbl_wd.val = wr_target;
    if (state == INIT) begin
      tbl_we = 1'b1;
      tbl_wi = cnt;
      tbl_wd = init_e;
    end
  end

  // Table storage has no reset of its own. The init sequence rewrites it.
  always_ff @(posedge clk) begin
    if (!reset && tbl_we)
      tbl[tbl_wi] <= tbl_wd;
  end

  // Resolve the lookup. Relative targets wrap modulo 2^D.
  always_comb begin
    rd_e = tbl[idx];
`ifdef BTT_BYPASS_EN
    if (wr_en && (wr_idx == idx)) begin
      rd_e.rel = wr_rel;
      rd_e.val = wr_target;
    end
`endif
    res = rd_e.rel ? (pc + rd_e.val) : rd_e.val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      cnt          <= '0;
      ready        <= 1'b0;
      target       <= '0;
      target_valid <= 1'b0;
    end else begin
      // Idle cycles drive a zero target so that consumers can OR targets.
      target       <= '0;
      target_valid <= 1'b0;
      case (state)
        INIT: begin
          cnt <= cnt + IW'(1);
          if (cnt == IW'(N - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          target_valid <= branch;
          if (branch)
            target <= res;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_target_table.sv
// Self-checking bench for branch_target_table (D = 8, N = 8).
module tb_branch_target_table;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       branch = 1'b0;
  logic [2:0] idx = '0;
  logic [7:0] pc = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [7:0] wr_target = '0;
  logic       wr_rel = 1'b0;
  logic       ready;
  logic [7:0] target;
  logic       target_valid;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      nm;
    logic       rdy;
    logic       vld;
    logic [7:0] tgt;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];

`ifdef BTT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  branch_target_table #(.D(8), .N(8)) dut (
    .clk(clk), .reset(reset), .branch(branch), .idx(idx), .pc(pc),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_target(wr_target), .wr_rel(wr_rel),
    .ready(ready), .target(target), .target_valid(target_valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle. Inputs are applied at the negedge and the expected
  // outcome is pushed at the same time. The output is captured 1 time unit
  // after the following posedge.
  task automatic cyc(input string nm, input logic rs, input logic br,
                     input logic [2:0] i, input logic [7:0] p,
                     input logic we, input logic [2:0] wi, input logic [7:0] wt,
                     input logic wr, input logic erdy, input logic evld,
                     input logic [7:0] etgt);
    item_t e, o;
    @(negedge clk);
    reset = rs; branch = br; idx = i; pc = p;
    wr_en = we; wr_idx = wi; wr_target = wt; wr_rel = wr;
    e.nm = nm; e.rdy = erdy; e.vld = evld; e.tgt = etgt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.nm = nm; o.rdy = ready; o.vld = target_valid; o.tgt = target;
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    item_t e, o;
    cyc("rst_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc("rst_hold", 1, 1, 0, 0, 1, 0, 8'h55, 0, 0, 0, 8'h00);
    // Branch is held high through init. ready rises only on the 8th edge.
    for (int k = 1; k <= 8; k++)
      cyc($sformatf("init_c%0d", k), 0, 1, 0, 8'h00, 0, 0, 0, 0,
          (k == 8), 0, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.rdy !== e.rdy || o.vld !== e.vld || o.tgt !== e.tgt) begin
        fails++;
        $display("FAIL %s: got rdy=%b vld=%b tgt=%h, want rdy=%b vld=%b tgt=%h",
                 e.nm, o.rdy, o.vld, o.tgt, e.rdy, e.vld, e.tgt);
      end
    end
  endtask

  task automatic test_defaults;
    item_t e, o;
    cyc("dflt_i0", 0, 1, 0, 8'h33, 0, 0, 0, 0, 1, 1, 8'h04);
    cyc("dflt_i1", 0, 1, 1, 8'h33, 0, 0, 0, 0, 1, 1, 8'h08);
    cyc("dflt_i5", 0, 1, 5, 8'h33, 0, 0, 0, 0, 1, 1, 8'h00);
    cyc("dflt_idle", 0, 0, 0, 8'h33, 0, 0, 0, 0, 1, 0, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.rdy !== e.rdy || o.vld !== e.vld || o.tgt !== e.tgt) begin
        fails++;
        $display("FAIL %s: got rdy=%b vld=%b tgt=%h, want rdy=%b vld=%b tgt=%h",
                 e.nm, o.rdy, o.vld, o.tgt, e.rdy, e.vld, e.tgt);
      end
    end
  endtask

  task automatic test_relative;
    item_t e, o;
    cyc("rel_wr_fe", 0, 0, 0, 0, 1, 3, 8'hFE, 1, 1, 0, 8'h00);
    cyc("rel_neg", 0, 1, 3, 8'h10, 0, 0, 0, 0, 1, 1, 8'h0E);
    cyc("rel_wr_05", 0, 0, 0, 0, 1, 3, 8'h05, 1, 1, 0, 8'h00);
    cyc("rel_wrap", 0, 1, 3, 8'hFD, 0, 0, 0, 0, 1, 1, 8'h02);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.rdy !== e.rdy || o.vld !== e.vld || o.tgt !== e.tgt) begin
        fails++;
        $display("FAIL %s: got rdy=%b vld=%b tgt=%h, want rdy=%b vld=%b tgt=%h",
                 e.nm, o.rdy, o.vld, o.tgt, e.rdy, e.vld, e.tgt);
      end
    end
  endtask

  task automatic test_same_cycle;
    item_t e, o;
    // Same index: whether the write is forwarded depends on the build.
    cyc("same_idx", 0, 1, 2, 8'h00, 1, 2, 8'h40, 0, 1, 1, BYP ? 8'h40 : 8'h00);
    cyc("same_next", 0, 1, 2, 8'h00, 0, 0, 0, 0, 1, 1, 8'h40);
    // Same index with a relative write. Entry 6 was absolute 0 before this.
    cyc("same_rel", 0, 1, 6, 8'h20, 1, 6, 8'h10, 1, 1, 1, BYP ? 8'h30 : 8'h00);
    cyc("same_rel_nx", 0, 1, 6, 8'h20, 0, 0, 0, 0, 1, 1, 8'h30);
    // Different indices: the write and the lookup are independent.
    cyc("diff_idx", 0, 1, 0, 8'h00, 1, 4, 8'h33, 0, 1, 1, 8'h04);
    cyc("diff_next", 0, 1, 4, 8'h00, 0, 0, 0, 0, 1, 1, 8'h33);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.rdy !== e.rdy || o.vld !== e.vld || o.tgt !== e.tgt) begin
        fails++;
        $display("FAIL %s: got rdy=%b vld=%b tgt=%h, want rdy=%b vld=%b tgt=%h",
                 e.nm, o.rdy, o.vld, o.tgt, e.rdy, e.vld, e.tgt);
      end
    end
  endtask

  task automatic test_idle_writes;
    item_t e, o;
    cyc("idle_wr5", 0, 0, 5, 8'h80, 1, 5, 8'h11, 0, 1, 0, 8'h00);
    cyc("idle_wr6", 0, 0, 6, 8'h80, 1, 6, 8'hF0, 1, 1, 0, 8'h00);
    cyc("idle_wr7", 0, 0, 7, 8'h80, 1, 7, 8'hC3, 0, 1, 0, 8'h00);
    cyc("b2b_i5", 0, 1, 5, 8'h05, 0, 0, 0, 0, 1, 1, 8'h11);
    cyc("b2b_i6", 0, 1, 6, 8'h05, 0, 0, 0, 0, 1, 1, 8'hF5);
    cyc("b2b_i7", 0, 1, 7, 8'h05, 0, 0, 0, 0, 1, 1, 8'hC3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.rdy !== e.rdy || o.vld !== e.vld || o.tgt !== e.tgt) begin
        fails++;
        $display("FAIL %s: got rdy=%b vld=%b tgt=%h, want rdy=%b vld=%b tgt=%h",
                 e.nm, o.rdy, o.vld, o.tgt, e.rdy, e.vld, e.tgt);
      end
    end
  endtask

  task automatic test_reinit;
    item_t e, o;
    cyc("ri_wr1", 0, 0, 0, 0, 1, 1, 8'h77, 0, 1, 0, 8'h00);
    cyc("ri_chk77", 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 8'h77);
    cyc("ri_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 4; k++)
      cyc($sformatf("ri_pre_c%0d", k), 0, 1, 1, 0, 1, 1, 8'h77, 0, 0, 0, 8'h00);
    // Reset arrives at init count 4. Init must restart from entry 0.
    cyc("ri_mid_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 8; k++)
      cyc($sformatf("ri_c%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, (k == 8), 0, 8'h00);
    cyc("ri_i1", 0, 1, 1, 8'h40, 0, 0, 0, 0, 1, 1, 8'h08);
    cyc("ri_i3", 0, 1, 3, 8'h40, 0, 0, 0, 0, 1, 1, 8'h00);
    cyc("ri_i0", 0, 1, 0, 8'h40, 0, 0, 0, 0, 1, 1, 8'h04);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.rdy !== e.rdy || o.vld !== e.vld || o.tgt !== e.tgt) begin
        fails++;
        $display("FAIL %s: got rdy=%b vld=%b tgt=%h, want rdy=%b vld=%b tgt=%h",
                 e.nm, o.rdy, o.vld, o.tgt, e.rdy, e.vld, e.tgt);
      end
    end
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_relative;
    test_same_cycle;
    test_idle_writes;
    test_reinit;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
